// File: rtl/cal_basis_sampler_pkg.sv
// Shared types and defaults for the basis-sweep calibration sampler.
package cal_basis_sampler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    EMIT,
    DONE
  } cal_sampler_state_t;

  localparam int unsigned CAL_NUM_INPUTS    = 2;
  localparam int unsigned CAL_NUM_OUTPUTS   = 2;
  localparam int unsigned CAL_DATA_WIDTH    = 16;
  localparam int unsigned CAL_ADC_WIDTH     = 12;
  localparam int unsigned CAL_SETTLE_CYCLES = 16;
  localparam int unsigned CAL_AVG_LOG2      = 3;
  localparam int unsigned CAL_AVG_SAMPLES   = 8;

  localparam logic [15:0] Q1_15_ONE = 16'h7FFF;

endpackage

// File: rtl/cal_basis_sampler_adc_channel_avg.sv
// One ADC channel: running sum, shift-average of the sum including the current beat, rail detect.
module adc_channel_avg
  import cal_basis_sampler_pkg::*;
#(
  parameter int unsigned ADC_WIDTH = CAL_ADC_WIDTH,
  parameter int unsigned AVG_LOG2  = CAL_AVG_LOG2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [ADC_WIDTH-1:0] data,
  output logic [ADC_WIDTH-1:0] avg_c,
  output logic                 sat_c
);

  localparam int unsigned ACC_W = ADC_WIDTH + AVG_LOG2;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] sum_c;

  assign sum_c = acc_q + ACC_W'(data);
  assign avg_c = ADC_WIDTH'(sum_c >> AVG_LOG2);
  assign sat_c = (data == '0) || (data == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sum_c;
    end
  end

endmodule

// File: rtl/cal_basis_sampler.sv
// Basis-sweep sampler: applies one-hot basis vectors, settles, averages ADC beats, streams columns.
module cal_basis_sampler
  import cal_basis_sampler_pkg::*;
#(
  parameter int unsigned N_IN          = CAL_NUM_INPUTS,
  parameter int unsigned N_OUT         = CAL_NUM_OUTPUTS,
  parameter int unsigned DATA_WIDTH    = CAL_DATA_WIDTH,
  parameter int unsigned ADC_WIDTH     = CAL_ADC_WIDTH,
  parameter int unsigned SETTLE_CYCLES = CAL_SETTLE_CYCLES,
  parameter int unsigned AVG_LOG2      = CAL_AVG_LOG2,
  parameter int unsigned COL_W         = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic [N_IN*DATA_WIDTH-1:0]  x_drive,
  output logic                        x_valid,
  input  logic [N_OUT*ADC_WIDTH-1:0]  adc_data,
  input  logic                        adc_valid,
  output logic [N_OUT*ADC_WIDTH-1:0]  meas_data,
  output logic [COL_W-1:0]            meas_col,
  output logic                        meas_valid,
  input  logic                        meas_ready,
  output logic                        sat_flag
);

  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned BEAT_W   = AVG_LOG2 + 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [BEAT_W-1:0]   BEAT_LAST   = BEAT_W'((1 << AVG_LOG2) - 1);
  localparam logic [COL_W-1:0]    LAST_COL    = COL_W'(N_IN - 1);

  cal_sampler_state_t state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;

  logic                       busy_d, done_d, x_valid_d, meas_valid_d, sat_d;
  logic [N_IN*DATA_WIDTH-1:0] x_drive_d;
  logic [N_OUT*ADC_WIDTH-1:0] meas_data_d;
  logic [COL_W-1:0]           meas_col_d;

  logic                       acc_clr_c, acc_en_c;
  logic [N_OUT*ADC_WIDTH-1:0] avg_c;
  logic [N_OUT-1:0]           sat_lane_c;

  for (genvar j = 0; j < N_OUT; j++) begin : g_chan
    adc_channel_avg #(
      .ADC_WIDTH(ADC_WIDTH),
      .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (acc_clr_c),
      .en   (acc_en_c),
      .data (adc_data[j*ADC_WIDTH +: ADC_WIDTH]),
      .avg_c(avg_c[j*ADC_WIDTH +: ADC_WIDTH]),
      .sat_c(sat_lane_c[j])
    );
  end

  // Next state plus next value of every registered output.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    settle_d    = settle_q;
    beat_d      = beat_q;
    sat_d       = sat_flag;
    meas_data_d = meas_data;
    acc_clr_c   = 1'b0;
    acc_en_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = APPLY;
          col_d   = '0;
          sat_d   = 1'b0;
        end
      end
      APPLY: begin
        settle_d = '0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      SAMPLE: begin
        if (adc_valid) begin
          acc_en_c = 1'b1;
          if (|sat_lane_c) begin
            sat_d = 1'b1;
          end
          if (beat_q == BEAT_LAST) begin
            beat_d      = '0;
            acc_clr_c   = 1'b1;
            meas_data_d = avg_c;
            state_d     = EMIT;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      EMIT: begin
        if (meas_ready) begin
          if (col_q == LAST_COL) begin
            state_d = DONE;
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = APPLY;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over everything, including a start in IDLE; sat_flag is kept.
    if (abort) begin
      state_d   = IDLE;
      col_d     = '0;
      settle_d  = '0;
      beat_d    = '0;
      sat_d     = sat_flag;
      acc_en_c  = 1'b0;
      acc_clr_c = 1'b1;
    end

    busy_d       = state_d inside {APPLY, SETTLE, SAMPLE, EMIT};
    done_d       = (state_d == DONE);
    x_valid_d    = busy_d;
    meas_valid_d = (state_d == EMIT);
    meas_col_d   = meas_valid_d ? col_d : '0;
    if (!meas_valid_d) begin
      meas_data_d = '0;
    end

    x_drive_d = '0;
    if (busy_d) begin
      for (int k = 0; k < N_IN; k++) begin
        if (col_d == COL_W'(k)) begin
          x_drive_d[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(Q1_15_ONE);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      settle_q   <= '0;
      beat_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      x_drive    <= '0;
      x_valid    <= 1'b0;
      meas_data  <= '0;
      meas_col   <= '0;
      meas_valid <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      settle_q   <= settle_d;
      beat_q     <= beat_d;
      busy       <= busy_d;
      done       <= done_d;
      x_drive    <= x_drive_d;
      x_valid    <= x_valid_d;
      meas_data  <= meas_data_d;
      meas_col   <= meas_col_d;
      meas_valid <= meas_valid_d;
      sat_flag   <= sat_d;
    end
  end

endmodule

// File: tb/tb_cal_basis_sampler.sv
// Scoreboard bench: default 2x2 sampler plus a 4x3 single-beat variant.
module tb_cal_basis_sampler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // default instance: N_IN=2, N_OUT=2, SETTLE=16, AVG_LOG2=3
  logic        start_a, abort_a, busy_a, done_a, x_valid_a;
  logic [31:0] x_drive_a;
  logic [23:0] adc_data_a, meas_data_a;
  logic        adc_valid_a, meas_valid_a, meas_ready_a, sat_flag_a;
  logic [0:0]  meas_col_a;

  // variant: N_IN=4, N_OUT=3, SETTLE=3, AVG_LOG2=0
  logic        start_b, abort_b, busy_b, done_b, x_valid_b;
  logic [63:0] x_drive_b;
  logic [35:0] adc_data_b, meas_data_b;
  logic        adc_valid_b, meas_valid_b, meas_ready_b, sat_flag_b;
  logic [1:0]  meas_col_b;

  cal_basis_sampler dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .x_drive(x_drive_a), .x_valid(x_valid_a),
    .adc_data(adc_data_a), .adc_valid(adc_valid_a),
    .meas_data(meas_data_a), .meas_col(meas_col_a), .meas_valid(meas_valid_a),
    .meas_ready(meas_ready_a), .sat_flag(sat_flag_a)
  );

  cal_basis_sampler #(
    .N_IN(4), .N_OUT(3), .SETTLE_CYCLES(3), .AVG_LOG2(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .x_drive(x_drive_b), .x_valid(x_valid_b),
    .adc_data(adc_data_b), .adc_valid(adc_valid_b),
    .meas_data(meas_data_b), .meas_col(meas_col_b), .meas_valid(meas_valid_b),
    .meas_ready(meas_ready_b), .sat_flag(sat_flag_b)
  );

  typedef struct {
    int          col;
    logic [63:0] data;
    int          cyc;
  } sb_t;

  sb_t sb_a[$];
  sb_t sb_b[$];
  int  n_err = 0;
  int  n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADC lane codes for the default instance, indexed by the edge that samples them
  function automatic logic [23:0] pat_a(input int mode, input int r);
    logic [11:0] l0, l1;
    case (mode)
      1: begin l0 = 12'(82 + (r % 26)); l1 = 12'(12'h500 + r); end
      2: begin l0 = 12'h321; l1 = 12'h321; end
      4: begin l0 = 12'h200; l1 = (r == 20) ? 12'hFFF : 12'h200; end
      default: begin l0 = 12'h400; l1 = 12'h400; end
    endcase
    return {l1, l0};
  endfunction

  function automatic logic [35:0] pat_b(input int r);
    logic [35:0] v;
    for (int j = 0; j < 3; j++) v[j*12 +: 12] = 12'(256 + 4*r + j);
    return v;
  endfunction

  // mode 0 plain, 1 ramp, 2 consumer stall, 3 abort in col-1 settle, 4 one saturated beat
  task automatic sweep_a(input int mode);
    int          t0, r, done_n, done_r, n_cols, s0, s1;
    logic        mv_prev;
    logic [23:0] v;
    sb_t         ent;
    n_cols = (mode == 3) ? 1 : 2;
    for (int c = 0; c < n_cols; c++) begin
      s0 = 0;
      s1 = 0;
      for (int i = 0; i < 8; i++) begin
        v  = pat_a(mode, c*26 + 18 + i);
        s0 += int'(v[11:0]);
        s1 += int'(v[23:12]);
      end
      ent.col  = c;
      ent.data = 64'({12'(s1 >> 3), 12'(s0 >> 3)});
      ent.cyc  = (mode == 2 && c == 1) ? 62 : c*26 + 26;
      sb_a.push_back(ent);
    end

    @(negedge clk);
    t0 = int'(cyc);
    done_n = 0;
    done_r = -1;
    mv_prev = 1'b0;
    start_a = 1'b1;
    abort_a = 1'b0;
    meas_ready_a = 1'b1;
    adc_valid_a = 1'b1;
    adc_data_a = pat_a(mode, 0);
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      r = int'(cyc) - t0;
      if (meas_valid_a && !mv_prev) begin
        if (sb_a.size() == 0) begin
          chk("a_extra_result", 64'(meas_valid_a), 64'd0);
        end else begin
          ent = sb_a.pop_front();
          chk("a_col", 64'(meas_col_a), 64'(ent.col));
          chk("a_data", 64'(meas_data_a), ent.data);
          chk("a_valid_cycle", 64'(r), 64'(ent.cyc));
        end
      end
      mv_prev = meas_valid_a;
      if (done_a) begin
        done_n++;
        done_r = r;
      end
      if (r == 1) chk("a_apply_flags", 64'({busy_a, x_valid_a, sat_flag_a}), 64'(3'b110));
      if (r == 10) chk("a_xdrive_col0", 64'(x_drive_a), 64'h0000_7FFF);
      if ((mode == 0 || mode == 1 || mode == 4) && r == 35)
        chk("a_xdrive_col1", 64'(x_drive_a), 64'h7FFF_0000);
      if (mode == 2 && r >= 27 && r <= 35)
        chk("a_stall_hold", 64'({meas_valid_a, meas_col_a, meas_data_a, x_drive_a}),
            64'({1'b1, 1'b0, 24'h321321, 32'h0000_7FFF}));
      if (mode == 3 && r == 31)
        chk("a_abort_idle", 64'({busy_a, x_valid_a, x_drive_a, meas_valid_a}), 64'd0);
      if (mode == 4 && (r == 19 || r == 21 || r == 53))
        chk("a_sat_flag", 64'(sat_flag_a), (r == 19) ? 64'd0 : 64'd1);
      start_a = 1'b0;
      abort_a = (mode == 3 && r == 30);
      meas_ready_a = !(mode == 2 && r >= 26 && r <= 35);
      adc_data_a = pat_a(mode, r);
    end
    if (mode == 3) begin
      chk("a_no_done_after_abort", 64'(done_n), 64'd0);
    end else begin
      chk("a_done_count", 64'(done_n), 64'd1);
      chk("a_done_cycle", 64'(done_r), (mode == 2) ? 64'd63 : 64'd53);
    end
    chk("a_sb_drained", 64'(sb_a.size()), 64'd0);
    sb_a.delete();
    chk("a_sat_end", 64'(sat_flag_a), (mode == 4) ? 64'd1 : 64'd0);
  endtask

  // adc_valid high on odd edges only; a second start mid-sweep must be ignored
  task automatic sweep_b();
    int   t0, r, a, e, done_n, done_r, done_exp;
    logic mv_prev;
    sb_t  ent;
    a = 1;
    for (int c = 0; c < 4; c++) begin
      e = a + 3 + 1;
      if (e % 2 == 0) e++;
      ent.col  = c;
      ent.data = 64'(pat_b(e));
      ent.cyc  = e + 1;
      sb_b.push_back(ent);
      a = e + 2;
    end
    done_exp = a;

    @(negedge clk);
    t0 = int'(cyc);
    done_n = 0;
    done_r = -1;
    mv_prev = 1'b0;
    start_b = 1'b1;
    adc_valid_b = 1'b0;
    adc_data_b = pat_b(0);
    meas_ready_b = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      r = int'(cyc) - t0;
      if (meas_valid_b && !mv_prev) begin
        if (sb_b.size() == 0) begin
          chk("b_extra_result", 64'(meas_valid_b), 64'd0);
        end else begin
          ent = sb_b.pop_front();
          chk("b_col", 64'(meas_col_b), 64'(ent.col));
          chk("b_data", 64'(meas_data_b), ent.data);
          chk("b_valid_cycle", 64'(r), 64'(ent.cyc));
        end
      end
      mv_prev = meas_valid_b;
      if (done_b) begin
        done_n++;
        done_r = r;
      end
      if (r == 13) chk("b_xdrive_col2_after_start", 64'(x_drive_b), 64'h0000_7FFF_0000_0000);
      start_b = (r == 12);
      adc_valid_b = (r % 2 == 1);
      adc_data_b = pat_b(r);
    end
    chk("b_done_count", 64'(done_n), 64'd1);
    chk("b_done_cycle", 64'(done_r), 64'(done_exp));
    chk("b_sb_drained", 64'(sb_b.size()), 64'd0);
    sb_b.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; adc_data_a = '0; adc_valid_a = 1'b0; meas_ready_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; adc_data_b = '0; adc_valid_b = 1'b0; meas_ready_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("a_reset_ctrl", 64'({busy_a, done_a, x_valid_a, meas_valid_a, sat_flag_a, meas_col_a}), 64'd0);
    chk("a_reset_data", 64'({x_drive_a, meas_data_a}), 64'd0);
    chk("b_reset_ctrl", 64'({busy_b, done_b, x_valid_b, meas_valid_b, sat_flag_b, meas_col_b, meas_data_b}), 64'd0);
    chk("b_reset_xdrive", 64'(x_drive_b), 64'd0);
    rst_n = 1'b1;

    @(negedge clk);
    start_a = 1'b1;
    abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    abort_a = 1'b0;
    chk("a_abort_with_start", 64'({busy_a, x_valid_a}), 64'd0);

    sweep_a(0);
    sweep_a(1);
    sweep_a(2);
    sweep_a(3);
    sweep_a(0);
    sweep_a(4);
    sweep_a(0);
    sweep_b();

    // asynchronous reset in the middle of sampling
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("a_async_reset", 64'({busy_a, x_valid_a, x_drive_a, meas_valid_a, meas_data_a}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
